// File: rtl/imem_boot_ctrl_if.sv
// Loader, memory-write and CPU-fetch signals of the instruction memory boot controller.
// The master side drives program load and PC; the slave side is the controller.
interface imem_boot_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic [ADDR_W:0]   prog_len;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [7:0]        mem_wdata;
  logic [31:0]       pc;
  logic [31:0]       mem_index;
  logic              cpu_run;
  logic              fault;
  logic [1:0]        fault_cause;
  logic [ADDR_W:0]   loaded_len;

  modport master (
    output start, prog_len, in_data, in_valid, pc,
    input  in_ready, mem_we, mem_waddr, mem_wdata, mem_index, cpu_run,
           fault, fault_cause, loaded_len
  );

  modport slave (
    input  start, prog_len, in_data, in_valid, pc,
    output in_ready, mem_we, mem_waddr, mem_wdata, mem_index, cpu_run,
           fault, fault_cause, loaded_len
  );
endinterface

// File: rtl/imem_boot_ctrl.sv
// Boot-load and fetch controller: streams a program into instruction memory,
// then releases the CPU and traps misaligned or out-of-program fetches.
module imem_boot_ctrl #(
  parameter int MEM_BYTES = 256,
  parameter int ADDR_W    = 8,
  parameter int TIMEOUT   = 1024
) (
  input logic             clk,
  input logic             rst,
  imem_boot_ctrl_if.slave bus
);

  localparam int LW   = ADDR_W + 1;
  localparam int TO_W = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [LW-1:0]     cnt_r, cnt_nxt_s;
  logic [LW-1:0]     len_r, len_nxt_s;
  logic [TO_W-1:0]   to_r, to_nxt_s;
  logic [1:0]        cause_r, cause_nxt_s;
  logic              hs_s;
  logic              pc_bad_s;
  logic              len_ok_s;
  logic              start_act_s;

  function automatic logic len_ok(input logic [LW-1:0] len);
    return (len != {LW{1'b0}}) && (len <= LW'(MEM_BYTES)) && (len[1:0] == 2'b00);
  endfunction

  assign hs_s        = (state_r == LOAD) && bus.in_valid;
  assign len_ok_s    = len_ok(bus.prog_len);
  assign start_act_s = bus.start && (state_r != LOAD);
  // loaded_len is at least 4 whenever RUN is reachable, so the subtraction cannot wrap.
  assign pc_bad_s    = (bus.pc[1:0] != 2'b00) ||
                       (bus.pc > ({{(32-LW){1'b0}}, len_r} - 32'd4));

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {LW{1'b0}};
      len_r   <= {LW{1'b0}};
      to_r    <= {TO_W{1'b0}};
      cause_r <= 2'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      len_r   <= len_nxt_s;
      to_r    <= to_nxt_s;
      cause_r <= cause_nxt_s;
    end
  end

  // Next-state logic; a start outside LOAD overrides any fetch trap
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    len_nxt_s   = len_r;
    to_nxt_s    = to_r;
    cause_nxt_s = cause_r;
    if (start_act_s) begin
      if (len_ok_s) begin
        state_nxt_s = LOAD;
        len_nxt_s   = bus.prog_len;
        cnt_nxt_s   = {LW{1'b0}};
        to_nxt_s    = {TO_W{1'b0}};
        cause_nxt_s = 2'd0;
      end else begin
        state_nxt_s = FAULT;
        cause_nxt_s = 2'd0;
      end
    end else begin
      case (state_r)
        LOAD: begin
          if (hs_s) begin
            cnt_nxt_s = cnt_r + LW'(1);
            to_nxt_s  = {TO_W{1'b0}};
            if (cnt_r == (len_r - LW'(1))) begin
              state_nxt_s = RUN;
            end else begin
              state_nxt_s = LOAD;
            end
          end else if ((TIMEOUT != 0) && (to_r == TO_W'(TIMEOUT - 1))) begin
            state_nxt_s = FAULT;
            cause_nxt_s = 2'd1;
          end else begin
            to_nxt_s = to_r + TO_W'(1);
          end
        end
        RUN: begin
          if (pc_bad_s) begin
            state_nxt_s = FAULT;
            cause_nxt_s = (bus.pc[1:0] != 2'b00) ? 2'd2 : 2'd3;
          end else begin
            state_nxt_s = RUN;
          end
        end
        IDLE:    state_nxt_s = IDLE;
        FAULT:   state_nxt_s = FAULT;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Output decode; cpu_run is gated by the fetch check in the same cycle
  always_comb begin
    bus.in_ready    = (state_r == LOAD);
    bus.mem_we      = hs_s;
    bus.mem_waddr   = {ADDR_W{1'b0}};
    bus.mem_wdata   = 8'd0;
    bus.mem_index   = 32'd0;
    bus.cpu_run     = 1'b0;
    bus.fault       = (state_r == FAULT);
    bus.fault_cause = cause_r;
    bus.loaded_len  = len_r;
    if (hs_s) begin
      bus.mem_waddr = cnt_r[ADDR_W-1:0];
      bus.mem_wdata = bus.in_data;
    end else begin
      bus.mem_waddr = {ADDR_W{1'b0}};
    end
    if (state_r == RUN) begin
      bus.mem_index = bus.pc;
      bus.cpu_run   = !pc_bad_s;
    end else begin
      bus.cpu_run = 1'b0;
    end
  end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Self-checking bench for imem_boot_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the controller.
module tb_imem_boot_ctrl;

  localparam int MEMB = 256;
  localparam int AW   = 8;
  localparam int TOUT = 8;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   wr_count;
  logic [7:0] tb_mem [MEMB];
  logic [7:0] hdr [4] = '{8'h20, 8'h01, 8'h00, 8'h14};

  imem_boot_ctrl_if #(.ADDR_W(AW)) bus_if ();

  imem_boot_ctrl #(.MEM_BYTES(MEMB), .ADDR_W(AW), .TIMEOUT(TOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: 0 idle, 1 loading, 2 running, 3 faulted
  int m_state, m_len, m_done, m_idle, m_cause;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_bad(input logic [31:0] p, input int len);
    longint unsigned pl;
    pl = p;
    return ((p % 32'd4) != 32'd0) || ((pl + 64'd4) > longint'(len));
  endfunction

  function automatic logic model_len_ok(input int len);
    return (len > 0) && (len <= MEMB) && ((len % 4) == 0);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state <= 0; m_len <= 0; m_done <= 0; m_idle <= 0; m_cause <= 0;
    end else if (m_state == 1) begin
      if (bus_if.in_valid) begin
        m_done <= m_done + 1;
        m_idle <= 0;
        if (m_done + 1 == m_len) m_state <= 2;
      end else if (m_idle + 1 >= TOUT) begin
        m_state <= 3; m_cause <= 1;
      end else begin
        m_idle <= m_idle + 1;
      end
    end else if (bus_if.start) begin
      if (model_len_ok(int'(bus_if.prog_len))) begin
        m_state <= 1; m_len <= int'(bus_if.prog_len); m_done <= 0; m_idle <= 0; m_cause <= 0;
      end else begin
        m_state <= 3; m_cause <= 0;
      end
    end else if (m_state == 2 && model_bad(bus_if.pc, m_len)) begin
      m_state <= 3;
      m_cause <= ((bus_if.pc % 32'd4) != 32'd0) ? 2 : 3;
    end
  end

  // Every-cycle comparison against the model, plus a copy of the written memory
  always @(negedge clk) begin
    logic e_we, e_run;
    e_we  = (m_state == 1) && bus_if.in_valid;
    e_run = (m_state == 2);
    chk("in_ready", 32'(bus_if.in_ready), 32'(m_state == 1));
    chk("mem_we", 32'(bus_if.mem_we), 32'(e_we));
    chk("mem_waddr", 32'(bus_if.mem_waddr), e_we ? 32'(m_done) : 32'd0);
    chk("mem_wdata", 32'(bus_if.mem_wdata), e_we ? 32'(bus_if.in_data) : 32'd0);
    chk("mem_index", bus_if.mem_index, e_run ? bus_if.pc : 32'd0);
    chk("cpu_run", 32'(bus_if.cpu_run), 32'(e_run && !model_bad(bus_if.pc, m_len)));
    chk("fault", 32'(bus_if.fault), 32'(m_state == 3));
    chk("fault_cause", 32'(bus_if.fault_cause), 32'(m_cause));
    chk("loaded_len", 32'(bus_if.loaded_len), 32'(m_len));
    if (bus_if.mem_we) begin
      tb_mem[bus_if.mem_waddr] = bus_if.mem_wdata;
      wr_count++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int len);
    bus_if.start    = 1'b1;
    bus_if.prog_len = 9'(len);
    tick();
    bus_if.start    = 1'b0;
  endtask

  task automatic send_bytes(input int n, input int stall);
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        repeat (stall) begin
          bus_if.in_valid = 1'b0;
          tick();
        end
      end
      bus_if.in_valid = 1'b1;
      bus_if.in_data  = (i < 4) ? hdr[i] : 8'($urandom);
      tick();
    end
    bus_if.in_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ready"}, 32'(bus_if.in_ready), 32'd0);
    chk({name, "_we"}, 32'(bus_if.mem_we), 32'd0);
    chk({name, "_wdata"}, 32'(bus_if.mem_wdata), 32'd0);
    chk({name, "_index"}, bus_if.mem_index, 32'd0);
    chk({name, "_run"}, 32'(bus_if.cpu_run), 32'd0);
    chk({name, "_fault"}, 32'(bus_if.fault), 32'd0);
    chk({name, "_cause"}, 32'(bus_if.fault_cause), 32'd0);
    chk({name, "_len"}, 32'(bus_if.loaded_len), 32'd0);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; wr_count = 0;
    rst = 1'b1;
    bus_if.start = 1'b0; bus_if.prog_len = 9'd0; bus_if.in_data = 8'hAA;
    bus_if.in_valid = 1'b1; bus_if.pc = 32'd0;
    repeat (2) tick();
    chk_all_zero("reset");
    rst = 1'b0;
    bus_if.in_valid = 1'b0;
    tick();

    // Basic load of 12 bytes with valid held high
    do_start(12);
    #1 chk("start_to_ready", 32'(bus_if.in_ready), 32'd1);
    wr_count = 0;
    send_bytes(12, 0);
    #1;
    chk("basic_run", 32'(bus_if.cpu_run), 32'd1);
    chk("basic_len", 32'(bus_if.loaded_len), 32'd12);
    chk("basic_writes", 32'(wr_count), 32'd12);
    chk("basic_word0", {tb_mem[0], tb_mem[1], tb_mem[2], tb_mem[3]}, 32'h20010014);

    // Fetch traps against a 12-byte program
    bus_if.pc = 32'd8;
    #1;
    chk("pc8_run", 32'(bus_if.cpu_run), 32'd1);
    chk("pc8_index", bus_if.mem_index, 32'd8);
    tick();
    bus_if.pc = 32'd12;
    #1;
    chk("pc12_run", 32'(bus_if.cpu_run), 32'd0);
    chk("pc12_nofault_yet", 32'(bus_if.fault), 32'd0);
    tick();
    chk("pc12_fault", 32'(bus_if.fault), 32'd1);
    chk("pc12_cause", 32'(bus_if.fault_cause), 32'd3);

    // Stalled loader restarted from FAULT
    bus_if.pc = 32'd0;
    do_start(12);
    #1 chk("reload_cause_clr", 32'(bus_if.fault_cause), 32'd0);
    wr_count = 0;
    send_bytes(12, 3);
    #1;
    chk("stall_run", 32'(bus_if.cpu_run), 32'd1);
    chk("stall_writes", 32'(wr_count), 32'd12);
    bus_if.pc = 32'd6;
    tick();
    chk("pc6_cause", 32'(bus_if.fault_cause), 32'd2);

    // Bad lengths from IDLE after a reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus_if.in_valid = 1'b1;
    foreach (hdr[k]) begin
      if (k < 3) begin
        do_start((k == 0) ? 10 : (k == 1) ? 0 : 260);
        #1;
        chk("badlen_fault", 32'(bus_if.fault), 32'd1);
        chk("badlen_cause", 32'(bus_if.fault_cause), 32'd0);
        chk("badlen_we", 32'(bus_if.mem_we), 32'd0);
        chk("badlen_len", 32'(bus_if.loaded_len), 32'd0);
      end
    end
    bus_if.in_valid = 1'b0;

    // Load timeout with no bytes
    do_start(16);
    repeat (7) tick();
    chk("to_still_load", 32'(bus_if.in_ready), 32'd1);
    tick();
    chk("to_fault", 32'(bus_if.fault), 32'd1);
    chk("to_cause", 32'(bus_if.fault_cause), 32'd1);

    // Asynchronous reset in the middle of a load
    do_start(12);
    send_bytes(5, 0);
    bus_if.in_valid = 1'b1;
    #2 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    tick();
    rst = 1'b0;
    bus_if.in_valid = 1'b0;

    // Reload while running
    do_start(8);
    send_bytes(8, 0);
    bus_if.pc = 32'd4;
    #1 chk("prereload_run", 32'(bus_if.cpu_run), 32'd1);
    bus_if.start = 1'b1;
    bus_if.prog_len = 9'd4;
    #1 chk("reload_start_cycle", 32'(bus_if.cpu_run), 32'd1);
    tick();
    bus_if.start = 1'b0;
    #1 chk("reload_drop", 32'(bus_if.cpu_run), 32'd0);
    bus_if.pc = 32'd0;
    send_bytes(4, 0);
    #1;
    chk("reload_run", 32'(bus_if.cpu_run), 32'd1);
    chk("reload_len", 32'(bus_if.loaded_len), 32'd4);

    // Randomized traffic checked by the model
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, 99);
      bus_if.start = ($urandom_range(0, 39) == 0);
      bus_if.prog_len = (r < 60) ? 9'(4 * $urandom_range(1, 16)) : 9'($urandom_range(0, 511));
      bus_if.in_valid = ($urandom_range(0, 99) < 75);
      bus_if.in_data = 8'($urandom);
      r = $urandom_range(0, 99);
      if (r < 70) bus_if.pc = 32'(4 * $urandom_range(0, 20));
      else if (r < 85) bus_if.pc = 32'($urandom_range(0, 80));
      else if (r < 92) bus_if.pc = 32'hFFFF_FFFC;
      else bus_if.pc = $urandom;
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    bus_if.start = 1'b0;
    bus_if.in_valid = 1'b0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
